// File: rtl/bcd_pkg.sv
// bcd_pkg: packed-BCD price type shared by the order book.
// Each price is four BCD digits. Because each nibble holds one decimal
// digit, comparing two prices as plain unsigned integers gives the same
// order as comparing their decimal values.
package bcd_pkg;

    localparam int PRICE_DIGITS = 4;

    typedef logic [4*PRICE_DIGITS-1:0] price_t;

endpackage

// File: rtl/ob_pkg.sv
// ob_pkg: order-book entry types and the price-priority helper.
// table_t is one resting order. The block carries uid and quantity
// unchanged; only price takes part in ordering.
package ob_pkg;

    typedef logic [7:0]  uid_t;
    typedef logic [15:0] quantity_t;

    typedef struct packed {
        uid_t            uid;
        quantity_t       quantity;
        bcd_pkg::price_t price;
    } table_t;

    // Strictly-better price: higher wins on the Bid side, lower on the Ask side.
    function automatic logic price_better(input logic            is_bid,
                                          input bcd_pkg::price_t a,
                                          input bcd_pkg::price_t b);
        if (is_bid) begin
            return a > b;
        end else begin
            return a < b;
        end
    endfunction

endpackage

// File: rtl/ob_table_reject_fifo.sv
// ob_table_reject_fifo: synchronous FIFO that holds rejected table entries.
// The head is registered, so head_data is valid in the cycle after the
// push or pop that exposes it.
// Ports: clk, rst (async, active-high); push/push_data write an entry;
//        pop removes the head. head_vld/head_data give the oldest entry,
//        and head_data is '0 when the FIFO is empty.
//        full means DEPTH entries are held.
// A push while full is accepted only if a pop happens in the same cycle.
// Otherwise the push is dropped, and the parent detects that case.
module ob_table_reject_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_data,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             push_ok, pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign head_vld  = head_vld_q;
    assign head_data = head_q;

    // Next-state for the storage, pointers, occupancy and registered head.
    always_comb begin
        pop_ok   = pop & (count_q != CW'(0));
        push_ok  = push & (~full | pop_ok);
        rd_next  = rd_ptr_q + AW'(1);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_next;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The head comes from the bypassed push data when the FIFO was
        // empty, or when the only stored entry is popped in the same cycle.
        if (count_d == CW'(0)) begin
            head_d = '0;
        end else if (count_q == CW'(0)) begin
            head_d = push_data;
        end else if (pop_ok) begin
            head_d = (count_q == CW'(1)) ? push_data : mem_q[rd_next];
        end else begin
            head_d = head_q;
        end
        head_vld_d = (count_d != CW'(0));
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

endmodule

// File: rtl/ob_table.sv
// ob_table: sorted, fixed-depth resting-order table for one side of the book.
// Entries are kept in price-time priority. On the Bid side (IS_BID=1)
// the highest price is at slot 0; on the Ask side the lowest price is.
// Ports: clk, rst (async, active-high);
//        insert/insert_tbl add an entry; pop removes the head entry;
//        reject_pop removes the oldest rejected entry.
//        table_vld_r/table_r give the head entry ('0 when the table is empty).
//        reject_vld_r/reject_r give the oldest rejected entry.
//        full_r means all N slots are occupied.
//        reject_overflow_r is sticky: a reject was dropped because the queue was full.
import ob_pkg::*;

module ob_table #(
    parameter int N        = 8,
    parameter bit IS_BID   = 1'b1,
    parameter int REJECT_N = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   insert,
    input  table_t insert_tbl,
    input  logic   pop,
    input  logic   reject_pop,
    output logic   table_vld_r,
    output table_t table_r,
    output logic   reject_vld_r,
    output table_t reject_r,
    output logic   full_r,
    output logic   reject_overflow_r
);
    localparam int PW = $clog2(N + 1);

    logic [N-1:0]  slot_vld_q, slot_vld_d;
    table_t        slot_q [N];
    table_t        slot_d [N];
    logic          overflow_q, overflow_d;

    logic          pop_act;
    logic [N-1:0]  post_vld;
    table_t        post_slot [N];
    logic [N-1:0]  ahead;
    logic [PW-1:0] ins_pos;
    logic          post_full, ins_ok, rej_push, rej_full;
    table_t        rej_data;

    // View of the table after any pop. Invalid slots always hold '0,
    // so table_r reads '0 once the table drains.
    always_comb begin
        pop_act = pop & slot_vld_q[0];
        for (int i = 0; i < N - 1; i++) begin
            if (pop_act) begin
                post_vld[i]  = slot_vld_q[i+1];
                post_slot[i] = slot_q[i+1];
            end else begin
                post_vld[i]  = slot_vld_q[i];
                post_slot[i] = slot_q[i];
            end
        end
        if (pop_act) begin
            post_vld[N-1]  = 1'b0;
            post_slot[N-1] = '0;
        end else begin
            post_vld[N-1]  = slot_vld_q[N-1];
            post_slot[N-1] = slot_q[N-1];
        end
    end

    // Insert position and reject decision.
    // The sorted valid slots that are equal to or better than the new entry
    // form a prefix. The new entry is placed at the first slot outside that prefix.
    always_comb begin
        ins_pos = PW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            ahead[i] = post_vld[i] &
                       ~price_better(IS_BID, insert_tbl.price, post_slot[i].price);
            ins_pos  = ahead[i] ? ins_pos : PW'(i);
        end
        post_full  = post_vld[N-1];
        ins_ok     = insert & (~post_full | (ins_pos != PW'(N)));
        // On a full table, either the displaced tail or the new entry itself is rejected.
        rej_push   = insert & post_full;
        rej_data   = ins_ok ? post_slot[N-1] : insert_tbl;
        overflow_d = overflow_q | (rej_push & rej_full & ~reject_pop);
    end

    // Shift-down insert into the post-pop view.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slot_vld_d[i] = post_vld[i];
            slot_d[i]     = post_slot[i];
        end
        if (ins_ok) begin
            for (int i = N - 1; i >= 1; i--) begin
                if (PW'(i) > ins_pos) begin
                    slot_vld_d[i] = post_vld[i-1];
                    slot_d[i]     = post_slot[i-1];
                end else if (PW'(i) == ins_pos) begin
                    slot_vld_d[i] = 1'b1;
                    slot_d[i]     = insert_tbl;
                end else begin
                    slot_vld_d[i] = post_vld[i];
                    slot_d[i]     = post_slot[i];
                end
            end
            if (ins_pos == PW'(0)) begin
                slot_vld_d[0] = 1'b1;
                slot_d[0]     = insert_tbl;
            end else begin
                slot_vld_d[0] = post_vld[0];
                slot_d[0]     = post_slot[0];
            end
        end else begin
            slot_vld_d = post_vld;
        end
    end

    // Slot array and sticky overflow flag with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
        end
    end

    ob_table_reject_fifo #(
        .WIDTH ($bits(table_t)),
        .DEPTH (REJECT_N)
    ) u_reject_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rej_push),
        .push_data (rej_data),
        .pop       (reject_pop),
        .head_vld  (reject_vld_r),
        .head_data (reject_r),
        .full      (rej_full)
    );

    assign table_vld_r       = slot_vld_q[0];
    assign table_r           = slot_q[0];
    assign full_r            = slot_vld_q[N-1];
    assign reject_overflow_r = overflow_q;

endmodule

// File: tb/tb_ob_table.sv
// tb_ob_table: drives an Ask table (N=8, REJECT_N=4) and a Bid table
// (N=4, REJECT_N=2) from shared strobes. Every cycle, both tables are
// compared against a price-time priority reference model. A constant
// vector table covers the directed Bid full/reject/overflow sequence.
`timescale 1ns/1ps
module tb_ob_table;
    import ob_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   insert, pop, reject_pop;
    table_t insert_tbl;

    logic   a_vld, a_rvld, a_full, a_ovf;
    table_t a_tbl, a_rej;
    logic   b_vld, b_rvld, b_full, b_ovf;
    table_t b_tbl, b_rej;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ob_table #(.N(8), .IS_BID(1'b0), .REJECT_N(4)) u_ask (
        .clk(clk), .rst(rst), .insert(insert), .insert_tbl(insert_tbl),
        .pop(pop), .reject_pop(reject_pop),
        .table_vld_r(a_vld), .table_r(a_tbl), .reject_vld_r(a_rvld),
        .reject_r(a_rej), .full_r(a_full), .reject_overflow_r(a_ovf));

    ob_table #(.N(4), .IS_BID(1'b1), .REJECT_N(2)) u_bid (
        .clk(clk), .rst(rst), .insert(insert), .insert_tbl(insert_tbl),
        .pop(pop), .reject_pop(reject_pop),
        .table_vld_r(b_vld), .table_r(b_tbl), .reject_vld_r(b_rvld),
        .reject_r(b_rej), .full_r(b_full), .reject_overflow_r(b_ovf));

    // ---------------- reference model (index 0 = ask, 1 = bid) -------------
    table_t mt [2][8];
    int     mcnt [2];
    table_t mr [2][4];
    int     mrc [2];
    bit     movf [2];

    function automatic int m_depth(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int m_rdepth(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic bit m_better(input int k, input logic [15:0] a, input logic [15:0] b);
        return (k == 0) ? (a < b) : (a > b);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mrc[k]  = 0;
            movf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit ins, input table_t e,
                              input bit p, input bit rp);
        int     n, pos;
        bit     do_ins, rej;
        table_t rv;
        n      = m_depth(k);
        rej    = 1'b0;
        rv     = '0;
        do_ins = ins;
        if (p && mcnt[k] > 0) begin
            for (int j = 0; j < mcnt[k] - 1; j++) mt[k][j] = mt[k][j+1];
            mcnt[k]--;
        end
        if (ins) begin
            // The new entry goes after every entry with an equal or better price.
            pos = 0;
            for (int j = 0; j < mcnt[k]; j++)
                if (!m_better(k, e.price, mt[k][j].price)) pos++;
            if (mcnt[k] == n) begin
                rej = 1'b1;
                if (pos < n) begin
                    rv = mt[k][n-1];
                    mcnt[k]--;
                end else begin
                    rv     = e;
                    do_ins = 1'b0;
                end
            end
            if (do_ins) begin
                for (int j = mcnt[k]; j > pos; j--) mt[k][j] = mt[k][j-1];
                mt[k][pos] = e;
                mcnt[k]++;
            end
        end
        if (rp && mrc[k] > 0) begin
            for (int j = 0; j < mrc[k] - 1; j++) mr[k][j] = mr[k][j+1];
            mrc[k]--;
        end
        if (rej) begin
            if (mrc[k] < m_rdepth(k)) begin
                mr[k][mrc[k]] = rv;
                mrc[k]++;
            end else begin
                movf[k] = 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            string  pf;
            table_t et, er;
            pf = (k == 0) ? "ask" : "bid";
            if (mcnt[k] > 0) et = mt[k][0]; else et = '0;
            if (mrc[k] > 0)  er = mr[k][0]; else er = '0;
            chk({pf, "_vld"},  64'(k == 0 ? a_vld  : b_vld),  64'(mcnt[k] > 0));
            chk({pf, "_tbl"},  64'(k == 0 ? a_tbl  : b_tbl),  64'(et));
            chk({pf, "_full"}, 64'(k == 0 ? a_full : b_full), 64'(mcnt[k] == m_depth(k)));
            chk({pf, "_rvld"}, 64'(k == 0 ? a_rvld : b_rvld), 64'(mrc[k] > 0));
            chk({pf, "_rej"},  64'(k == 0 ? a_rej  : b_rej),  64'(er));
            chk({pf, "_ovf"},  64'(k == 0 ? a_ovf  : b_ovf),  64'(movf[k]));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_vld"},  64'(a_vld),  64'(0));
        chk({tag, "_a_tbl"},  64'(a_tbl),  64'(0));
        chk({tag, "_a_rvld"}, 64'(a_rvld), 64'(0));
        chk({tag, "_a_rej"},  64'(a_rej),  64'(0));
        chk({tag, "_a_full"}, 64'(a_full), 64'(0));
        chk({tag, "_a_ovf"},  64'(a_ovf),  64'(0));
        chk({tag, "_b_vld"},  64'(b_vld),  64'(0));
        chk({tag, "_b_tbl"},  64'(b_tbl),  64'(0));
        chk({tag, "_b_rvld"}, 64'(b_rvld), 64'(0));
        chk({tag, "_b_rej"},  64'(b_rej),  64'(0));
        chk({tag, "_b_full"}, 64'(b_full), 64'(0));
        chk({tag, "_b_ovf"},  64'(b_ovf),  64'(0));
    endtask

    // One clock cycle of strobes. Outputs are checked 1 ns after the edge.
    task automatic step(input bit i, input logic [7:0] u, input logic [15:0] pr,
                        input bit p, input bit rp);
        table_t e;
        e.uid      = u;
        e.quantity = quantity_t'($urandom);
        e.price    = pr;
        insert     = i;
        insert_tbl = e;
        pop        = p;
        reject_pop = rp;
        @(posedge clk);
        model_step(0, i, e, p, rp);
        model_step(1, i, e, p, rp);
        #1;
        insert     = 1'b0;
        pop        = 1'b0;
        reject_pop = 1'b0;
        check_model();
    endtask

    function automatic logic [15:0] rand_price();
        logic [3:0] d1, d0;
        d1 = 4'($urandom_range(0, 3));
        d0 = 4'($urandom_range(0, 9));
        return {8'h00, d1, d0};
    endfunction

    // ---------------- directed Bid vector table ----------------
    typedef struct packed {
        bit          ins;
        logic [7:0]  uid;
        logic [15:0] price;
        bit          p;
        bit          rp;
        bit          ev;
        logic [7:0]  eu;
        logic [15:0] ep;
        bit          ef;
        bit          erv;
        logic [7:0]  eru;
        bit          eo;
    } vec_t;

    localparam int NV = 26;
    vec_t vt [NV];

    initial begin
        vt[0]  = '{1'b1, 8'd1,  16'h0050, 1'b0, 1'b0, 1'b1, 8'd1,  16'h0050, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[1]  = '{1'b1, 8'd2,  16'h0050, 1'b0, 1'b0, 1'b1, 8'd1,  16'h0050, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[2]  = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 8'd2,  16'h0050, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[3]  = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[4]  = '{1'b1, 8'd10, 16'h0040, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[5]  = '{1'b1, 8'd11, 16'h0030, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[6]  = '{1'b1, 8'd12, 16'h0020, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[7]  = '{1'b1, 8'd13, 16'h0010, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b1, 1'b0, 8'd0,  1'b0};
        vt[8]  = '{1'b1, 8'd14, 16'h0025, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b1, 1'b1, 8'd13, 1'b0};
        vt[9]  = '{1'b1, 8'd15, 16'h0005, 1'b0, 1'b0, 1'b1, 8'd10, 16'h0040, 1'b1, 1'b1, 8'd13, 1'b0};
        vt[10] = '{1'b1, 8'd16, 16'h0005, 1'b1, 1'b0, 1'b1, 8'd11, 16'h0030, 1'b1, 1'b1, 8'd13, 1'b0};
        vt[11] = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 8'd14, 16'h0025, 1'b0, 1'b1, 8'd13, 1'b0};
        vt[12] = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 8'd12, 16'h0020, 1'b0, 1'b1, 8'd13, 1'b0};
        vt[13] = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 8'd16, 16'h0005, 1'b0, 1'b1, 8'd13, 1'b0};
        vt[14] = '{1'b0, 8'd0,  16'h0000, 1'b1, 1'b0, 1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 8'd13, 1'b0};
        vt[15] = '{1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 8'd15, 1'b0};
        vt[16] = '{1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 1'b0, 8'd0,  16'h0000, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[17] = '{1'b1, 8'd20, 16'h0040, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[18] = '{1'b1, 8'd21, 16'h0030, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[19] = '{1'b1, 8'd22, 16'h0020, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b0, 1'b0, 8'd0,  1'b0};
        vt[20] = '{1'b1, 8'd23, 16'h0010, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b0, 8'd0,  1'b0};
        vt[21] = '{1'b1, 8'd24, 16'h0001, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b1, 8'd24, 1'b0};
        vt[22] = '{1'b1, 8'd25, 16'h0002, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b1, 8'd24, 1'b0};
        vt[23] = '{1'b1, 8'd26, 16'h0003, 1'b0, 1'b0, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b1, 8'd24, 1'b1};
        vt[24] = '{1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b1, 8'd25, 1'b1};
        vt[25] = '{1'b0, 8'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 8'd20, 16'h0040, 1'b1, 1'b0, 8'd0,  1'b1};

        rst        = 1'b1;
        insert     = 1'b0;
        pop        = 1'b0;
        reject_pop = 1'b0;
        insert_tbl = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Ask ordering: 105, 100, 110 drain as 100, 105, 110.
        step(1'b1, 8'd1, 16'h0105, 1'b0, 1'b0);
        step(1'b1, 8'd2, 16'h0100, 1'b0, 1'b0);
        step(1'b1, 8'd3, 16'h0110, 1'b0, 1'b0);
        chk("ask_head_100", 64'(a_tbl.price), 64'(16'h0100));
        step(1'b0, 8'd0, 16'h0000, 1'b1, 1'b0);
        chk("ask_pop1_105", 64'(a_tbl.price), 64'(16'h0105));
        step(1'b0, 8'd0, 16'h0000, 1'b1, 1'b0);
        chk("ask_pop2_110", 64'(a_tbl.price), 64'(16'h0110));
        step(1'b0, 8'd0, 16'h0000, 1'b1, 1'b0);
        chk("ask_pop3_empty", 64'(a_vld), 64'(0));

        // Clean start for the Bid vector table.
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("rst2");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NV; v++) begin
            step(vt[v].ins, vt[v].uid, vt[v].price, vt[v].p, vt[v].rp);
            chk($sformatf("vec%0d_vld", v),  64'(b_vld),         64'(vt[v].ev));
            chk($sformatf("vec%0d_uid", v),  64'(b_tbl.uid),     64'(vt[v].eu));
            chk($sformatf("vec%0d_prc", v),  64'(b_tbl.price),   64'(vt[v].ep));
            chk($sformatf("vec%0d_full", v), 64'(b_full),        64'(vt[v].ef));
            chk($sformatf("vec%0d_rvld", v), 64'(b_rvld),        64'(vt[v].erv));
            chk($sformatf("vec%0d_ruid", v), 64'(b_rej.uid),     64'(vt[v].eru));
            chk($sformatf("vec%0d_ovf", v),  64'(b_ovf),         64'(vt[v].eo));
        end

        // Asynchronous reset with the Bid table half full, asserted between clock edges.
        step(1'b0, 8'd0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 8'd0, 16'h0000, 1'b1, 1'b0);
        chk("half_full_vld", 64'(b_vld), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'd77, 16'h0077, 1'b0, 1'b0);
        chk("post_rst_b_77", 64'(b_tbl.price), 64'(16'h0077));
        chk("post_rst_a_77", 64'(a_tbl.uid),   64'(8'd77));

        // Randomised traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom), rand_price(),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < ((c < 300) ? 3 : 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
